// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch and data ports; one outstanding transaction, data lanes aligned/extended.
// Latency: accept -> bus_req next cycle, response one cycle after bus_rvalid (3 cycles minimum).
// Backpressure: ready only in IDLE; bus_gnt stalls REQ, timeout after MAX_WAIT WAIT cycles. Macro MEM_BUS_ARBITER_FAIR_EN enables tie alternation.
module mem_bus_arbiter #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_error,
    input  logic        d_load,
    input  logic        d_store,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        d_any;
    logic        pick_d;
    logic        i_acc;
    logic        d_acc;
    logic        d_ill;
    logic        timeout;
    logic        owner_d;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_signed;
    logic [7:0]  wait_cnt;
    logic [3:0]  d_strb;
    logic [31:0] d_lane_wdata;
    logic [31:0] rd_shift;
    logic [31:0] load_data;

    assign d_any = d_load | d_store;

`ifdef MEM_BUS_ARBITER_FAIR_EN
    // last_owner: 1 = data port won the most recent grant
    logic last_owner;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_owner <= 1'b0;
        end else if (i_acc || d_acc) begin
            last_owner <= d_acc;
        end
    end

    always_comb begin
        pick_d = d_any;
        if (d_any && i_req) begin
            pick_d = !last_owner;
        end
    end
`else
    always_comb begin
        pick_d = d_any;
    end
`endif

    assign i_ready = (state == ST_IDLE) && reset_n && i_req && !pick_d;
    assign d_ready = (state == ST_IDLE) && reset_n && d_any && pick_d;
    assign i_acc   = i_ready;
    assign d_acc   = d_ready;
    assign d_ill   = d_acc && (d_size == 2'b11);
    assign bus_req = (state == ST_REQ);
    assign timeout = (state == ST_WAIT) && !bus_rvalid && (wait_cnt == WAIT_LAST);

    always_comb begin
        d_strb = 4'hF;
        case (d_size)
            2'b00:   d_strb = 4'b0001 << d_addr[1:0];
            2'b01:   d_strb = 4'b0011 << d_addr[1:0];
            default: d_strb = 4'hF;
        endcase
    end

    assign d_lane_wdata = d_wdata << {d_addr[1:0], 3'b000};
    assign rd_shift     = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        load_data = rd_shift;
        case (r_size)
            2'b00:   load_data = r_signed ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                          : {24'b0, rd_shift[7:0]};
            2'b01:   load_data = r_signed ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                          : {16'b0, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_acc || (d_acc && !d_ill)) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_gnt) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus_rvalid || timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner_d   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'b0;
            bus_wdata <= 32'b0;
            bus_strb  <= 4'b0;
            r_size    <= 2'b0;
            r_off     <= 2'b0;
            r_signed  <= 1'b0;
            wait_cnt  <= 8'b0;
            i_rvalid  <= 1'b0;
            i_rdata   <= 32'b0;
            i_error   <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= 32'b0;
            d_error   <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            i_error  <= 1'b0;
            d_rvalid <= 1'b0;
            d_error  <= 1'b0;

            if (i_acc) begin
                owner_d   <= 1'b0;
                bus_we    <= 1'b0;
                bus_addr  <= i_addr & ~32'h3;
                bus_wdata <= 32'b0;
                bus_strb  <= 4'hF;
                r_size    <= 2'b10;
                r_off     <= 2'b00;
                r_signed  <= 1'b0;
            end else if (d_acc && !d_ill) begin
                owner_d   <= 1'b1;
                bus_we    <= d_store;
                bus_addr  <= d_addr & ~32'h3;
                bus_wdata <= d_lane_wdata;
                bus_strb  <= d_strb;
                r_size    <= d_size;
                r_off     <= d_addr[1:0];
                r_signed  <= d_signed;
            end

            // illegal size never reaches the bus; answered directly from IDLE
            if (d_ill) begin
                d_rvalid <= 1'b1;
                d_error  <= 1'b1;
                d_rdata  <= 32'b0;
            end

            if ((state == ST_REQ) && bus_gnt) begin
                wait_cnt <= 8'b0;
            end else if ((state == ST_WAIT) && !bus_rvalid) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if ((state == ST_WAIT) && bus_rvalid) begin
                if (owner_d) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= bus_we ? 32'b0 : load_data;
                end else begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= bus_rdata;
                end
            end else if (timeout) begin
                if (owner_d) begin
                    d_rvalid <= 1'b1;
                    d_error  <= 1'b1;
                    d_rdata  <= 32'b0;
                end else begin
                    i_rvalid <= 1'b1;
                    i_error  <= 1'b1;
                    i_rdata  <= 32'b0;
                end
            end
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory bus between the instruction-fetch port and the memory-stage data port of the pipeline. It accepts one request at a time with a valid/ready handshake and drives one outstanding bus transaction. It routes the response back to the owning requester, with byte-lane alignment and load sign-extension for the data port. It sits between fetch/memory and the bus, and its `*_ready`/`*_rvalid` signals feed the hazard unit's stall logic.

## Interface
Parameters:
- `MAX_WAIT`, default 255: cycles allowed in WAIT before a bus timeout error; legal range 1..255.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `i_req` in 1: fetch request.
- `i_addr` in 32: fetch address, word-aligned.
- `i_ready` out 1: fetch request accepted this cycle.
- `i_rvalid` out 1: one-cycle fetch response pulse.
- `i_rdata` out 32: fetch data.
- `i_error` out 1: fetch bus error, qualified by `i_rvalid`.
- `d_load` in 1: data load request.
- `d_store` in 1: data store request.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data, right-aligned.
- `d_size` in 2: access size; 00 byte, 01 half, 10 word, 11 illegal.
- `d_signed` in 1: sign-extend load data.
- `d_ready` out 1: data request accepted.
- `d_rvalid` out 1: data response pulse; also marks store completion.
- `d_rdata` out 32: extracted load data; 0 for stores.
- `d_error` out 1: data error, qualified by `d_rvalid`.
- `bus_req` out 1: bus request.
- `bus_we` out 1: write enable.
- `bus_addr` out 32: word address, with bits [1:0] = 0.
- `bus_wdata` out 32: lane-shifted write data.
- `bus_strb` out 4: byte strobes.
- `bus_gnt` in 1: bus accepts the request this cycle.
- `bus_rvalid` in 1: bus response.
- `bus_rdata` in 32: bus read data.

## Operation
- **States.** IDLE, REQ, WAIT.
- **Acceptance.** Requests are accepted only in IDLE.
  - `x_ready` is combinational: `(state==IDLE) && reset_n && selected`.
  - A request is accepted when req and ready are both high in the same cycle.
  - On acceptance, the address, we, wdata, strb, size, signed and owner are registered, and the state goes to REQ.
- **Arbitration.** When both ports request in the same cycle, the data port wins. Fairness is configurable (see Configuration).
- **Illegal size.** `d_size`=11 is accepted but never goes to the bus. A response is issued the next cycle with `d_rvalid`=1 and `d_error`=1, and the state stays IDLE.
- **Data-port alignment.** The data port is assumed aligned; the memory stage filters misaligned accesses. The arbiter does not check `d_addr` alignment.
- **Strobes.** With `o = addr[1:0]`:
  - byte: `strb = 1<<o`.
  - half: `strb = 3<<o`.
  - word: `strb = 4'hF`.
- **Write data.** `bus_wdata = d_wdata << (8*o)`.
- **Fetch accesses.** Fetch always uses word size, `we`=0 and `strb`=4'hF.
- **REQ state.** `bus_req`=1 and the registered fields are held stable until `bus_gnt`. Then the state goes to WAIT and the timeout counter clears.
- **WAIT state.** On `bus_rvalid`, the owner's response is registered: `x_rvalid`=1 next cycle, `x_error`=0, and the state returns to IDLE.
  - Load data is `bus_rdata >> (8*o)`, truncated to the access size.
  - Zero- or sign-extension follows `d_signed`.
  - The counter increments each WAIT cycle without `bus_rvalid`. Reaching MAX_WAIT issues an error response to the owner with rdata 0, and the state returns to IDLE.
- **Stray responses.** `bus_rvalid` in IDLE or REQ is ignored.
- **Reset.** All registers clear, and the state goes to IDLE.
  - `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_strb` reset to 0.
  - `i_rvalid`, `i_rdata`, `i_error`, `d_rvalid`, `d_rdata`, `d_error` reset to 0.
  - Reset mid-transaction drops the transaction; no response is ever issued for it.

## Timing
- Acceptance in cycle 0 gives `bus_req`=1 in cycle 1.
- If `bus_gnt` arrives in cycle 1, WAIT is entered in cycle 2.
- `bus_rvalid` in cycle k gives `x_rvalid` in cycle k+1, when IDLE is also re-entered. A new request may be accepted in cycle k+1.
- Minimum request-to-response latency is 3 cycles; throughput is one transaction per 3 cycles at best.
- `x_rvalid`/`x_error` are single-cycle pulses; `x_rdata` holds its value until the next response.
- The timeout fires on the edge after the MAX_WAIT-th consecutive WAIT cycle without `bus_rvalid`. `bus_rvalid` in that same cycle takes priority and produces a normal response.

## Configuration
- `MEM_BUS_ARBITER_FAIR_EN`:
  - **Defined:** a 1-bit `last_owner` register (reset = fetch) records each grant. On a tie, the port that did not win the last grant is selected. This gives strict alternation under continuous contention, with the data port winning the first tie after reset.
  - **Undefined:** the data port always wins ties and `last_owner` is not built.

## Test plan
- Word load `d_addr`=0x1000, `bus_gnt` immediate, `bus_rvalid` 2 cycles later with 0xDEADBEEF -> `bus_addr`=0x1000, `strb`=1111, `d_rvalid` one cycle after `bus_rvalid`, `d_rdata`=0xDEADBEEF.
- Byte load at 0x1003, `bus_rdata`=0x80112233 -> `bus_addr`=0x1000, `strb`=1000; `d_rdata` is 0xFFFFFF80 with signed, 0x00000080 unsigned.
- Half store at 0x2002 with `d_wdata`=0x0000ABCD, `bus_gnt` delayed 3 cycles -> `bus_we`=1, `strb`=1100, `bus_wdata`=0xABCD0000, all held stable while `bus_req`=1; `d_rvalid`=1 with `d_rdata`=0.
- `i_req` and `d_load` held together for 4 transactions -> without FAIR_EN the order is D,D,D,D; with FAIR_EN it is D,I,D,I; `x_ready` is never high outside IDLE.
- MAX_WAIT=4 and `bus_rvalid` never arrives -> `d_rvalid`=1 and `d_error`=1 on the edge after the 4th WAIT cycle; a late `bus_rvalid` in IDLE produces no response.
- `reset_n`=0 during WAIT -> next cycle all outputs 0 and state IDLE; a subsequent `bus_rvalid` is ignored.
